// File: rtl/gamma_pipe_mc.sv
// gamma_pipe_mc
//   Multi-channel gamma (branch-metric) pipeline for the parallel turbo decoder.
//   Per channel c:  ba1ba3    = s(ba1) + ba3          (M+1 bits, cannot overflow)
//                   ba1ba2ba3 = sat(ba1ba3 + ba2)     (clipped to M+1 bits)
//   s() is selected per beat by scale_sel: x1, x0.75, x0.5 or x0 (floor rounding).
//
// Ports
//   Clock, nReset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      input beat handshake, in_last marks the frame's last beat
//   scale_sel              a-priori scaling, sampled with the beat
//   ba1_i/ba2_i/ba3_i      P packed channels (M, N, N bits)
//   out_valid/out_ready    output beat handshake, out_last aligned with its beat
//   ba1ba3_o/ba1ba2ba3_o   P packed channels of M+1 bits
//   sat_o                  per-channel clip flag of the current output beat
//   sat_cnt_o              frame saturation count, meaningful when out_valid && out_last
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high. valid never depends on ready; in_ready depends
// combinationally on out_ready. A full stage whose successor can take its beat
// reloads in the same cycle, so the pipeline runs at one beat per cycle.
module gamma_pipe_mc #(
   parameter int N      = 5,
   parameter int M      = 6,
   parameter int P      = 4,
   parameter int STAGES = 1,
   parameter int CW     = 16
) (
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   input  logic [1:0]           scale_sel,
   input  logic [P*M-1:0]       ba1_i,
   input  logic [P*N-1:0]       ba2_i,
   input  logic [P*N-1:0]       ba3_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [P*(M+1)-1:0]   ba1ba3_o,
   output logic [P*(M+1)-1:0]   ba1ba2ba3_o,
   output logic [P-1:0]         sat_o,
   output logic [CW-1:0]        sat_cnt_o
);

   localparam int PCW = $clog2(P + 1);
   localparam int TW  = ((CW > PCW) ? CW : PCW) + 1;

   // Arithmetic shifts floor toward -inf; 3*a needs two guard bits.
   function automatic logic [M-1:0] scale_f(input logic [M-1:0] a, input logic [1:0] sel);
      logic [M+1:0] ext;
      logic [M+1:0] tri3;
      logic [M-1:0] r;
      ext  = {{2{a[M-1]}}, a};
      tri3 = ext + {ext[M:0], 1'b0};
      case (sel)
         2'b00:   r = a;
         2'b01:   r = tri3[M+1:2];
         2'b10:   r = {a[M-1], a[M-1:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [M:0] add13_f(input logic [M-1:0] s, input logic [N-1:0] b3);
      return {s[M-1], s} + {{(M+1-N){b3[N-1]}}, b3};
   endfunction

   // Returns {clip_flag, clipped_sum}. Overflow of M+1 bits shows as the top two
   // bits of the M+2 bit sum disagreeing; the top bit gives the direction.
   function automatic logic [M+1:0] add2_sat_f(input logic [M:0] b13, input logic [N-1:0] b2);
      logic [M+1:0] sum;
      logic [M:0]   r;
      logic         ovf;
      sum = {b13[M], b13} + {{(M+2-N){b2[N-1]}}, b2};
      ovf = sum[M+1] ^ sum[M];
      if (ovf) r = sum[M+1] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
      else     r = sum[M:0];
      return {ovf, r};
   endfunction

   logic [P*(M+1)-1:0] in_b13;
   logic [P*(M+1)-1:0] s_b123;
   logic [P-1:0]       s_sat;

   // Output stage registers (last stage in either configuration).
   logic               out_v_q;
   logic               out_last_q;
   logic [P*(M+1)-1:0] out_b13_q;
   logic [P*(M+1)-1:0] out_b123_q;
   logic [P-1:0]       out_sat_q;
   logic               out_free;

   always_comb begin
      in_b13 = '0;
      for (int c = 0; c < P; c++)
         in_b13[c*(M+1) +: M+1] = add13_f(scale_f(ba1_i[c*M +: M], scale_sel), ba3_i[c*N +: N]);
   end

   // Output stage can take a new beat when empty or when its beat leaves now.
   assign out_free = !out_v_q || out_ready;

   generate
      if (STAGES == 1) begin : g_one
         always_comb begin
            s_b123 = '0;
            s_sat  = '0;
            for (int c = 0; c < P; c++)
               {s_sat[c], s_b123[c*(M+1) +: M+1]} = add2_sat_f(in_b13[c*(M+1) +: M+1], ba2_i[c*N +: N]);
         end

         assign in_ready = out_free;

         always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
               out_v_q    <= 1'b0;
               out_last_q <= 1'b0;
               out_b13_q  <= '0;
               out_b123_q <= '0;
               out_sat_q  <= '0;
            end else begin
               if (out_free) out_v_q <= in_valid;
               if (in_valid && out_free) begin
                  out_last_q <= in_last;
                  out_b13_q  <= in_b13;
                  out_b123_q <= s_b123;
                  out_sat_q  <= s_sat;
               end
            end
         end
      end else begin : g_two
         logic               a_v_q;
         logic               a_last_q;
         logic [P*(M+1)-1:0] a_b13_q;
         logic [P*N-1:0]     a_b2_q;

         always_comb begin
            s_b123 = '0;
            s_sat  = '0;
            for (int c = 0; c < P; c++)
               {s_sat[c], s_b123[c*(M+1) +: M+1]} = add2_sat_f(a_b13_q[c*(M+1) +: M+1], a_b2_q[c*N +: N]);
         end

         assign in_ready = !a_v_q || out_free;

         always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
               a_v_q    <= 1'b0;
               a_last_q <= 1'b0;
               a_b13_q  <= '0;
               a_b2_q   <= '0;
            end else begin
               if (in_ready) a_v_q <= in_valid;
               if (in_valid && in_ready) begin
                  a_last_q <= in_last;
                  a_b13_q  <= in_b13;
                  a_b2_q   <= ba2_i;
               end
            end
         end

         always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
               out_v_q    <= 1'b0;
               out_last_q <= 1'b0;
               out_b13_q  <= '0;
               out_b123_q <= '0;
               out_sat_q  <= '0;
            end else begin
               if (out_free) out_v_q <= a_v_q;
               if (a_v_q && out_free) begin
                  out_last_q <= a_last_q;
                  out_b13_q  <= a_b13_q;
                  out_b123_q <= s_b123;
                  out_sat_q  <= s_sat;
               end
            end
         end
      end
   endgenerate

   // Frame saturation statistics. The reported count already includes the
   // beat on the output, so the final beat of a frame carries the full total.
   logic [PCW-1:0] pop;
   logic [TW-1:0]  tot;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  acc_q;
   logic [CW-1:0]  acc_d;

   always_comb begin
      pop = '0;
      for (int c = 0; c < P; c++)
         pop = pop + PCW'(out_sat_q[c]);
      tot   = TW'(acc_q) + TW'(pop);
      cnt   = (tot > TW'({CW{1'b1}})) ? {CW{1'b1}} : tot[CW-1:0];
      acc_d = acc_q;
      if (out_v_q && out_ready) acc_d = out_last_q ? '0 : cnt;
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) acc_q <= '0;
      else         acc_q <= acc_d;
   end

   assign out_valid   = out_v_q;
   assign out_last    = out_last_q;
   assign ba1ba3_o    = out_b13_q;
   assign ba1ba2ba3_o = out_b123_q;
   assign sat_o       = out_sat_q;
   assign sat_cnt_o   = cnt;

endmodule

// File: tb/tb_gamma_pipe_mc.sv
`timescale 1ns/1ps
module tb_gamma_pipe_mc;

   localparam int M  = 6;
   localparam int N  = 6;
   localparam int P  = 4;
   localparam int CA = 16;
   localparam int CB = 2;
   localparam int OW = P*(M+1);
   localparam int EW = 1 + P + 2*OW;

   typedef struct packed {
      logic          last;
      logic [P-1:0]  sat;
      logic [OW-1:0] b13;
      logic [OW-1:0] b123;
   } exp_t;

   typedef struct {
      logic [1:0] sel;
      int         a1, a2, a3;
      logic       last;
      int         e13, e123;
      logic       esat;
      int         ecnt;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic nReset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A: STAGES=1, CW=16 ----------------
   logic           a_iv = 1'b0, a_ir, a_il = 1'b0;
   logic [1:0]     a_sel = '0;
   logic [P*M-1:0] a_ba1 = '0;
   logic [P*N-1:0] a_ba2 = '0, a_ba3 = '0;
   logic           a_ov, a_ordy = 1'b1, a_ol;
   logic [OW-1:0]  a_b13, a_b123;
   logic [P-1:0]   a_sat;
   logic [CA-1:0]  a_cnt;

   gamma_pipe_mc #(.N(N), .M(M), .P(P), .STAGES(1), .CW(CA)) u_a (
      .Clock(clk), .nReset(nReset),
      .in_valid(a_iv), .in_ready(a_ir), .in_last(a_il), .scale_sel(a_sel),
      .ba1_i(a_ba1), .ba2_i(a_ba2), .ba3_i(a_ba3),
      .out_valid(a_ov), .out_ready(a_ordy), .out_last(a_ol),
      .ba1ba3_o(a_b13), .ba1ba2ba3_o(a_b123), .sat_o(a_sat), .sat_cnt_o(a_cnt)
   );

   // ---------------- DUT B: STAGES=2, CW=2 ----------------
   logic           b_iv = 1'b0, b_ir, b_il = 1'b0;
   logic [1:0]     b_sel = '0;
   logic [P*M-1:0] b_ba1 = '0;
   logic [P*N-1:0] b_ba2 = '0, b_ba3 = '0;
   logic           b_ov, b_ordy = 1'b1, b_ol;
   logic [OW-1:0]  b_b13, b_b123;
   logic [P-1:0]   b_sat;
   logic [CB-1:0]  b_cnt;

   gamma_pipe_mc #(.N(N), .M(M), .P(P), .STAGES(2), .CW(CB)) u_b (
      .Clock(clk), .nReset(nReset),
      .in_valid(b_iv), .in_ready(b_ir), .in_last(b_il), .scale_sel(b_sel),
      .ba1_i(b_ba1), .ba2_i(b_ba2), .ba3_i(b_ba3),
      .out_valid(b_ov), .out_ready(b_ordy), .out_last(b_ol),
      .ba1ba3_o(b_b13), .ba1ba2ba3_o(b_b123), .sat_o(b_sat), .sat_cnt_o(b_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_a_q[$];
   logic [EW-1:0] exp_b_q[$];
   int acc_a = 0, acc_b = 0;
   int vec_cnt = 0, miscompares = 0;
   bit done_a, done_b;
   exp_t ea, eb;
   int tot_a, tot_b;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vec_cnt++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int fdiv(input int x, input int d);
      return (x >= 0) ? x / d : -((-x + d - 1) / d);
   endfunction

   function automatic exp_t model(input logic [1:0] sel, input logic [P*M-1:0] a1,
                                  input logic [P*N-1:0] a2, input logic [P*N-1:0] a3,
                                  input logic last);
      exp_t e;
      int x, s, t, u;
      e.last = last; e.sat = '0; e.b13 = '0; e.b123 = '0;
      for (int c = 0; c < P; c++) begin
         x = int'($signed(a1[c*M +: M]));
         case (sel)
            2'd0:    s = x;
            2'd1:    s = fdiv(3 * x, 4);
            2'd2:    s = fdiv(x, 2);
            default: s = 0;
         endcase
         t = s + int'($signed(a3[c*N +: N]));
         u = t + int'($signed(a2[c*N +: N]));
         if (u > 2**M - 1)   begin u = 2**M - 1; e.sat[c] = 1'b1; end
         else if (u < -(2**M)) begin u = -(2**M); e.sat[c] = 1'b1; end
         e.b13[c*(M+1) +: M+1]  = t[M:0];
         e.b123[c*(M+1) +: M+1] = u[M:0];
      end
      return e;
   endfunction

   function automatic int popc(input logic [P-1:0] s);
      int n = 0;
      for (int c = 0; c < P; c++) n += int'(s[c]);
      return n;
   endfunction

   function automatic logic [OW-1:0] rep7(input int v);
      logic [OW-1:0] r;
      for (int c = 0; c < P; c++) r[c*(M+1) +: M+1] = v[M:0];
      return r;
   endfunction

   function automatic logic [P*M-1:0] repM(input int v);
      logic [P*M-1:0] r;
      for (int c = 0; c < P; c++) r[c*M +: M] = v[M-1:0];
      return r;
   endfunction

   function automatic logic [P*N-1:0] repN(input int v);
      logic [P*N-1:0] r;
      for (int c = 0; c < P; c++) r[c*N +: N] = v[N-1:0];
      return r;
   endfunction

   // Channels below k carry max positive values (saturate at scale x1), others 0.
   function automatic logic [P*M-1:0] satM(input int k);
      logic [P*M-1:0] r = '0;
      int v = 2**(M-1) - 1;
      for (int c = 0; c < P; c++) if (c < k) r[c*M +: M] = v[M-1:0];
      return r;
   endfunction

   function automatic logic [P*N-1:0] satN(input int k);
      logic [P*N-1:0] r = '0;
      int v = 2**(N-1) - 1;
      for (int c = 0; c < P; c++) if (c < k) r[c*N +: N] = v[N-1:0];
      return r;
   endfunction

   // ---------------- monitor: compares every output against the queue ----------------
   always @(negedge clk) begin
      if (nReset) begin
         // DUT A: single stage, so occupancy is exactly the queue depth
         chk("a_in_ready", a_ir, !(exp_a_q.size() == 1 && !a_ordy));
         chk("a_out_valid", a_ov, exp_a_q.size() == 1);
         if (a_ov && exp_a_q.size() > 0) begin
            ea = exp_t'(exp_a_q[0]);
            chk("a_b13", a_b13, ea.b13);
            chk("a_b123", a_b123, ea.b123);
            chk("a_sat", a_sat, ea.sat);
            chk("a_last", a_ol, ea.last);
            if (a_ordy) begin
               void'(exp_a_q.pop_front());
               tot_a = acc_a + popc(ea.sat);
               if (ea.last) begin
                  chk("a_sat_cnt", a_cnt, (tot_a > 2**CA - 1) ? 2**CA - 1 : tot_a);
                  acc_a = 0;
               end else acc_a = tot_a;
            end
         end
         if (a_iv && a_ir) exp_a_q.push_back(model(a_sel, a_ba1, a_ba2, a_ba3, a_il));

         // DUT B: two stages
         chk("b_in_ready", b_ir, !(exp_b_q.size() == 2 && !b_ordy));
         if (exp_b_q.size() == 2) chk("b_full_valid", b_ov, 1);
         if (b_ov) begin
            if (exp_b_q.size() == 0) chk("b_unexpected_valid", b_ov, 0);
            else begin
               eb = exp_t'(exp_b_q[0]);
               chk("b_b13", b_b13, eb.b13);
               chk("b_b123", b_b123, eb.b123);
               chk("b_sat", b_sat, eb.sat);
               chk("b_last", b_ol, eb.last);
               if (b_ordy) begin
                  void'(exp_b_q.pop_front());
                  tot_b = acc_b + popc(eb.sat);
                  if (eb.last) begin
                     chk("b_sat_cnt", b_cnt, (tot_b > 2**CB - 1) ? 2**CB - 1 : tot_b);
                     acc_b = 0;
                  end else acc_b = tot_b;
               end
            end
         end
         if (b_iv && b_ir) exp_b_q.push_back(model(b_sel, b_ba1, b_ba2, b_ba3, b_il));
      end
   end

   // ---------------- driver tasks ----------------
   // Presents a beat and returns 1ns after the edge on which it was accepted.
   task automatic send(input int id, input logic [1:0] sel, input logic [P*M-1:0] a1,
                       input logic [P*N-1:0] a2, input logic [P*N-1:0] a3, input logic last);
      bit ok = 0;
      if (id == 0) begin a_sel = sel; a_ba1 = a1; a_ba2 = a2; a_ba3 = a3; a_il = last; a_iv = 1'b1; end
      else         begin b_sel = sel; b_ba1 = a1; b_ba2 = a2; b_ba3 = a3; b_il = last; b_iv = 1'b1; end
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if ((id == 0) ? a_ir : b_ir) ok = 1;
      end
      @(posedge clk); #1;
      if (id == 0) a_iv = 1'b0; else b_iv = 1'b0;
      chk("send_accepted", ok, 1);
   endtask

   task automatic rand_stream(input int id, input int nb);
      for (int i = 0; i < nb; i++) begin
         send(id, 2'($urandom_range(0, 3)), (P*M)'($urandom), (P*N)'($urandom), (P*N)'($urandom),
              (i == nb - 1) || ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic drain();
      a_ordy = 1'b1; b_ordy = 1'b1;
      for (int k = 0; k < 20 && (exp_a_q.size() + exp_b_q.size()) > 0; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("drain_a", exp_a_q.size(), 0);
      chk("drain_b", exp_b_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      //        sel    a1   a2   a3  last  e13  e123 esat ecnt
      tbl[0] = '{2'd1,  -3,   1,   2, 1'b0,  -1,   0, 1'b0, 0};
      tbl[1] = '{2'd0,  31,  31,  31, 1'b1,  62,  63, 1'b1, 4};
      tbl[2] = '{2'd0, -32, -32, -32, 1'b0, -64, -64, 1'b1, 0};
      tbl[3] = '{2'd3, -32, -32, -32, 1'b1, -32, -64, 1'b0, 4};
      tbl[4] = '{2'd2,  -5,   0,   0, 1'b0,  -3,  -3, 1'b0, 0};
      tbl[5] = '{2'd1,  31, -32, -32, 1'b0,  -9, -41, 1'b0, 0};
      tbl[6] = '{2'd1, -32,  31,  31, 1'b0,   7,  38, 1'b0, 0};
      tbl[7] = '{2'd2,  31,  31,  31, 1'b1,  46,  63, 1'b1, 4};
      tbl[8] = '{2'd1,  -1,   0,   0, 1'b1,  -1,  -1, 1'b0, 0};
      tbl[9] = '{2'd2,  -1, -32, -32, 1'b1, -33, -64, 1'b1, 4};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_in_ready", a_ir, 1);
      chk("rst_a_out_valid", a_ov, 0);
      chk("rst_a_last", a_ol, 0);
      chk("rst_a_data", {a_b13, a_b123}, 0);
      chk("rst_a_sat", a_sat, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_b_in_ready", b_ir, 1);
      chk("rst_b_out_valid", b_ov, 0);
      chk("rst_b_data", {b_sat, b_b13, b_b123, b_cnt}, 0);
      nReset = 1'b1;
      @(posedge clk); #1;

      // directed table on the single-stage instance, one-cycle latency
      for (int i = 0; i < 10; i++) begin
         send(0, tbl[i].sel, repM(tbl[i].a1), repN(tbl[i].a2), repN(tbl[i].a3), tbl[i].last);
         chk($sformatf("tbl%0d_valid", i), a_ov, 1);
         chk($sformatf("tbl%0d_b13", i), a_b13, rep7(tbl[i].e13));
         chk($sformatf("tbl%0d_b123", i), a_b123, rep7(tbl[i].e123));
         chk($sformatf("tbl%0d_sat", i), a_sat, {P{tbl[i].esat}});
         chk($sformatf("tbl%0d_last", i), a_ol, tbl[i].last);
         if (tbl[i].last) chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].ecnt);
      end

      // frame of 1,0,2 saturations followed directly by a one-beat frame with 1
      send(0, 2'd0, satM(1), satN(1), satN(1), 1'b0);
      send(0, 2'd0, satM(0), satN(0), satN(0), 1'b0);
      send(0, 2'd0, satM(2), satN(2), satN(2), 1'b1);
      chk("frame3_cnt", a_cnt, 3);
      send(0, 2'd0, satM(1), satN(1), satN(1), 1'b1);
      chk("frame1_cnt", a_cnt, 1);
      drain();

      // two-stage latency
      send(1, 2'd0, repM(1), repN(2), repN(3), 1'b1);
      chk("b_lat_1", b_ov, 0);
      @(posedge clk); #1;
      chk("b_lat_2", b_ov, 1);
      chk("b_lat_b123", b_b123, rep7(6));
      drain();

      // randomized streams on both instances with random backpressure
      done_a = 0; done_b = 0;
      fork
         begin rand_stream(0, 40); done_a = 1; end
         begin rand_stream(1, 60); done_b = 1; end
         begin
            while (!(done_a && done_b)) begin
               @(posedge clk); #1;
               a_ordy = 1'($urandom_range(0, 1));
               b_ordy = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();

      // counter saturation with CW=2: 4 + 1 events report 3
      send(1, 2'd0, satM(4), satN(4), satN(4), 1'b0);
      send(1, 2'd0, satM(1), satN(1), satN(1), 1'b1);
      @(posedge clk); #1;
      chk("cw2_last", b_ol, 1);
      chk("cw2_cnt", b_cnt, 3);
      drain();

      // reset mid-frame with two beats in flight
      send(1, 2'd0, satM(2), satN(2), satN(2), 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      b_ordy = 1'b0;
      send(1, 2'd0, satM(1), satN(1), satN(1), 1'b0);
      send(1, 2'd0, satM(1), satN(1), satN(1), 1'b0);
      @(negedge clk);
      nReset = 1'b0;
      #1;
      chk("mid_rst_valid", b_ov, 0);
      chk("mid_rst_in_ready", b_ir, 1);
      chk("mid_rst_last", b_ol, 0);
      chk("mid_rst_data", {b_b13, b_b123}, 0);
      chk("mid_rst_sat", b_sat, 0);
      chk("mid_rst_cnt", b_cnt, 0);
      exp_a_q.delete(); exp_b_q.delete();
      acc_a = 0; acc_b = 0;
      @(posedge clk); #2;
      nReset = 1'b1;
      b_ordy = 1'b1;
      @(posedge clk); #1;
      send(1, 2'd0, satM(1), satN(1), satN(1), 1'b1);
      @(posedge clk); #1;
      chk("post_rst_last", b_ol, 1);
      chk("post_rst_cnt", b_cnt, 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
